// File: rtl/lms_pkg.sv
// Shared constants for the LMS tap adapter: PAM4 levels/thresholds, Gray symbol codes,
// FSM encodings and the tap saturation helper.
package lms_pkg;

  localparam int IN_BW   = 11;
  localparam int OUT_BW  = 9;
  localparam int COEF_BW = 9;
  localparam int N_COEF  = 7;
  localparam int ERR_BW  = OUT_BW + 1;
  // Wide enough for e*x plus rounding and tap accumulation at any MU_SHIFT up to 10
  localparam int ACC_W   = 24;

  localparam int LVL_P1 = 32;
  localparam int LVL_P3 = 96;
  localparam int LVL_N1 = -32;
  localparam int LVL_N3 = -96;
  localparam int THR    = 64;

  localparam logic [1:0] SYM_N3 = 2'b00;
  localparam logic [1:0] SYM_N1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b11;
  localparam logic [1:0] SYM_P3 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_ADAPT  = 2'b10,
    ST_HOLD   = 2'b11
  } state_e;

  localparam logic signed [COEF_BW-1:0] COEF_ONE = 9'sd128;
  localparam logic signed [ACC_W-1:0]   SAT_HI   = ACC_W'((2 ** (COEF_BW - 1)) - 1);
  localparam logic signed [ACC_W-1:0]   SAT_LO   = ACC_W'(-(2 ** (COEF_BW - 1)));

  function automatic logic signed [COEF_BW-1:0] sat_coef(input logic signed [ACC_W-1:0] v);
    logic signed [COEF_BW-1:0] r;
    if (v > SAT_HI) begin
      r = SAT_HI[COEF_BW-1:0];
    end else if (v < SAT_LO) begin
      r = SAT_LO[COEF_BW-1:0];
    end else begin
      r = v[COEF_BW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pam4_slicer.sv
// Combinational PAM4 decision on the FFE output: level d, Gray symbol and error e = d - y.
module pam4_slicer
  import lms_pkg::*;
(
  input  logic signed [OUT_BW-1:0] y,
  output logic        [1:0]        symbol,
  output logic signed [ERR_BW-1:0] err
);

  localparam logic signed [ERR_BW-1:0] THR_P = ERR_BW'(THR);
  localparam logic signed [ERR_BW-1:0] THR_N = ERR_BW'(-THR);

  logic signed [ERR_BW-1:0] y_ext_s;
  logic signed [ERR_BW-1:0] d_s;

  assign y_ext_s = {y[OUT_BW-1], y};

  // Threshold compare into the nearest of the four levels
  always_comb begin
    d_s    = ERR_BW'(LVL_P3);
    symbol = SYM_P3;
    if (y_ext_s < THR_N) begin
      d_s    = ERR_BW'(LVL_N3);
      symbol = SYM_N3;
    end else if (y_ext_s[ERR_BW-1]) begin
      d_s    = ERR_BW'(LVL_N1);
      symbol = SYM_N1;
    end else if (y_ext_s < THR_P) begin
      d_s    = ERR_BW'(LVL_P1);
      symbol = SYM_P1;
    end else begin
      d_s    = ERR_BW'(LVL_P3);
      symbol = SYM_P3;
    end
    err = d_s - y_ext_s;
  end

endmodule

// File: rtl/lms_coef_update.sv
// Sign-exact LMS adaptation of the FFE taps, driven by the PAM4 slicer error and the
// same x window the FFE multiplies; taps feed straight back to the FFE coefficient bus.
module lms_coef_update
  import lms_pkg::*;
#(
  parameter int MU_SHIFT   = 8,
  parameter int SETTLE_SYM = 16,
  parameter int CENTER     = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_en,
  input  logic [IN_BW-1:0]            i_data,
  input  logic [OUT_BW-1:0]           i_ffe_out,
  input  logic                        i_adapt_en,
  input  logic                        i_reinit,
  output logic [COEF_BW*N_COEF-1:0]   o_coefs,
  output logic [1:0]                  o_symbol,
  output logic [ERR_BW-1:0]           o_error,
  output logic [1:0]                  o_state
);

  localparam int CNT_W = $clog2(SETTLE_SYM + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SYM - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam int SHIFT = 7 + MU_SHIFT;
  localparam logic signed [ACC_W-1:0] RND = {{(ACC_W-1){1'b0}}, 1'b1} << (6 + MU_SHIFT);

  state_e                    state_r, state_nxt_s;
  logic [CNT_W-1:0]          cnt_r;
  logic signed [IN_BW-1:0]   dl_r       [N_COEF-1];
  logic signed [COEF_BW-1:0] coef_r     [N_COEF];
  logic signed [COEF_BW-1:0] coef_nxt_s [N_COEF];
  logic signed [IN_BW-1:0]   x_s        [N_COEF];
  logic [1:0]                sym_s;
  logic signed [ERR_BW-1:0]  err_s;
  logic update_en_s, load_init_s, cnt_clr_s, cnt_inc_s;

  // Rounded (half up), shifted, saturated single-tap step
  function automatic logic signed [COEF_BW-1:0] lms_step(
    input logic signed [COEF_BW-1:0] c,
    input logic signed [IN_BW-1:0]   x,
    input logic signed [ERR_BW-1:0]  e
  );
    logic signed [ACC_W-1:0] p;
    logic signed [ACC_W-1:0] u;
    p = ACC_W'(e) * ACC_W'(x);
    u = (p + RND) >>> SHIFT;
    return sat_coef(ACC_W'(c) + u);
  endfunction

  pam4_slicer u_slicer (
    .y      (i_ffe_out),
    .symbol (sym_s),
    .err    (err_s)
  );

  // Tap window with the same alignment as the FFE products
  always_comb begin
    x_s[0] = i_data;
    for (int k = 1; k < N_COEF; k++) begin
      x_s[k] = dl_r[k-1];
    end
  end

  // Candidate new tap values for this strobe
  always_comb begin
    for (int k = 0; k < N_COEF; k++) begin
      coef_nxt_s[k] = lms_step(coef_r[k], x_s[k], err_s);
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; reinit overrides everything
  always_comb begin
    state_nxt_s = state_r;
    if (i_reinit) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:   state_nxt_s = i_adapt_en ? ST_SETTLE : ST_IDLE;
        ST_SETTLE: begin
          if (!i_adapt_en) begin
            state_nxt_s = ST_IDLE;
          end else if (i_en && (cnt_r == SETTLE_LAST)) begin
            state_nxt_s = ST_ADAPT;
          end else begin
            state_nxt_s = ST_SETTLE;
          end
        end
        ST_ADAPT:  state_nxt_s = i_adapt_en ? ST_ADAPT : ST_HOLD;
        ST_HOLD:   state_nxt_s = i_adapt_en ? ST_ADAPT : ST_HOLD;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM datapath controls
  always_comb begin
    load_init_s = i_reinit;
    update_en_s = 1'b0;
    cnt_clr_s   = 1'b0;
    cnt_inc_s   = 1'b0;
    if (!i_reinit) begin
      case (state_r)
        ST_IDLE:   cnt_clr_s   = i_adapt_en;
        ST_SETTLE: cnt_inc_s   = i_adapt_en & i_en;
        ST_ADAPT:  update_en_s = i_adapt_en & i_en;
        ST_HOLD:   update_en_s = 1'b0;
        default:   update_en_s = 1'b0;
      endcase
    end else begin
      update_en_s = 1'b0;
    end
  end

  // Settle symbol counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r <= '0;
    end else if (load_init_s || cnt_clr_s) begin
      cnt_r <= '0;
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Tap registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_COEF; k++) begin
        coef_r[k] <= (k == CENTER) ? COEF_ONE : '0;
      end
    end else if (load_init_s) begin
      for (int k = 0; k < N_COEF; k++) begin
        coef_r[k] <= (k == CENTER) ? COEF_ONE : '0;
      end
    end else if (update_en_s) begin
      for (int k = 0; k < N_COEF; k++) begin
        coef_r[k] <= coef_nxt_s[k];
      end
    end
  end

  // Sample delay line, advancing on every symbol regardless of state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_COEF - 1; k++) begin
        dl_r[k] <= '0;
      end
    end else if (i_en) begin
      dl_r[0] <= i_data;
      for (int k = 1; k < N_COEF - 1; k++) begin
        dl_r[k] <= dl_r[k-1];
      end
    end
  end

  // Registered decision and error, held between strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_symbol <= 2'b00;
      o_error  <= '0;
    end else if (i_en) begin
      o_symbol <= sym_s;
      o_error  <= err_s;
    end
  end

  for (genvar k = 0; k < N_COEF; k++) begin : g_pack
    assign o_coefs[k*COEF_BW +: COEF_BW] = coef_r[k];
  end

  assign o_state = state_r;

endmodule

// File: tb/tb_lms_coef_update.sv
// Scoreboard bench for lms_coef_update (MU_SHIFT=0): directed vectors push expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_lms_coef_update;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_en;
  logic [10:0] i_data;
  logic [8:0]  i_ffe_out;
  logic        i_adapt_en;
  logic        i_reinit;
  logic [62:0] o_coefs;
  logic [1:0]  o_symbol;
  logic [9:0]  o_error;
  logic [1:0]  o_state;

  localparam logic [62:0] INIT_COEFS = 63'h4_0000_0000;

  typedef struct {
    logic [62:0] coefs;
    logic [1:0]  sym;
    logic [9:0]  err;
    logic [1:0]  st;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_ex;
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  int mc[7];
  int mdl[6];
  int mst, mcnt, msym, merr;

  lms_coef_update #(.MU_SHIFT(0), .SETTLE_SYM(16), .CENTER(3)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (i_en),
    .i_data     (i_data),
    .i_ffe_out  (i_ffe_out),
    .i_adapt_en (i_adapt_en),
    .i_reinit   (i_reinit),
    .o_coefs    (o_coefs),
    .o_symbol   (o_symbol),
    .o_error    (o_error),
    .o_state    (o_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 255) ? 255 : ((v < -256) ? -256 : v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 7; k++) mc[k] = (k == 3) ? 128 : 0;
    for (int k = 0; k < 6; k++) mdl[k] = 0;
    mst = 0; mcnt = 0; msym = 0; merr = 0;
  endtask

  task automatic model_step(input bit en, input int x, input int y, input bit adapt, input bit reinit);
    int d, e, xk, g;
    if (y < -64)      begin d = -96; g = 0; end
    else if (y < 0)   begin d = -32; g = 1; end
    else if (y < 64)  begin d = 32;  g = 3; end
    else              begin d = 96;  g = 2; end
    e = d - y;
    if (reinit) begin
      for (int k = 0; k < 7; k++) mc[k] = (k == 3) ? 128 : 0;
      mcnt = 0; mst = 0;
    end else begin
      case (mst)
        0: if (adapt) begin mst = 1; mcnt = 0; end
        1: begin
          if (!adapt) mst = 0;
          else if (en) begin
            if (mcnt == 15) mst = 2;
            mcnt++;
          end
        end
        2: begin
          if (!adapt) mst = 3;
          else if (en) begin
            for (int k = 0; k < 7; k++) begin
              xk = (k == 0) ? x : mdl[k-1];
              mc[k] = clamp(mc[k] + ((e * xk + 64) >>> 7));
            end
          end
        end
        default: if (adapt) mst = 2;
      endcase
    end
    if (en) begin
      for (int k = 5; k > 0; k--) mdl[k] = mdl[k-1];
      mdl[0] = x;
      msym = g;
      merr = e;
    end
  endtask

  // Drive one clock of stimulus and queue the expected response
  task automatic cycle(input bit en, input int x, input int y, input bit adapt, input bit reinit,
                       input bit hand, input int hsym, input int herr);
    exp_t ex;
    @(negedge clk);
    i_en = en; i_data = x[10:0]; i_ffe_out = y[8:0]; i_adapt_en = adapt; i_reinit = reinit;
    @(posedge clk);
    #1;
    model_step(en, x, y, adapt, reinit);
    for (int k = 0; k < 7; k++) ex.coefs[k*9 +: 9] = mc[k][8:0];
    ex.sym = hand ? hsym[1:0] : msym[1:0];
    ex.err = hand ? herr[9:0] : merr[9:0];
    ex.st  = mst[1:0];
    ex.id  = vec_id;
    vec_id++;
    sb_q.push_back(ex);
  endtask

  // Monitor: registered outputs are stable at the negedge after each driven clock
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_ex = sb_q.pop_front();
      chk($sformatf("coefs v%0d", mon_ex.id), {1'b0, o_coefs}, {1'b0, mon_ex.coefs});
      chk($sformatf("symbol v%0d", mon_ex.id), {62'd0, o_symbol}, {62'd0, mon_ex.sym});
      chk($sformatf("error v%0d", mon_ex.id), {54'd0, o_error}, {54'd0, mon_ex.err});
      chk($sformatf("state v%0d", mon_ex.id), {62'd0, o_state}, {62'd0, mon_ex.st});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sl_y[6];
    int sl_s[6];
    int sl_e[6];
    sl_y = '{-65, -64, -1, 0, 63, 64};
    sl_s = '{0, 1, 1, 3, 3, 2};
    sl_e = '{-31, 32, -31, 32, -31, 32};

    rst_n = 1'b0; i_en = 1'b0; i_data = 11'd0; i_ffe_out = 9'd0;
    i_adapt_en = 1'b0; i_reinit = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_coefs", {1'b0, o_coefs}, {1'b0, INIT_COEFS});
    chk("rst_state", {62'd0, o_state}, 64'd0);
    chk("rst_symbol", {62'd0, o_symbol}, 64'd0);
    chk("rst_error", {54'd0, o_error}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Slicer boundaries, idle state
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 100 + i, sl_y[i], 1'b0, 1'b0, 1'b1, sl_s[i], sl_e[i]);
      chk("slicer_sym", {62'd0, o_symbol}, 64'(sl_s[i]));
    end
    cycle(1'b0, 7, 100, 1'b0, 1'b0, 1'b1, sl_s[5], sl_e[5]);

    // Settle: 16 strobes before adaptation, x=0 keeps the delay line clear
    cycle(1'b0, 0, 20, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("enter_settle", {62'd0, o_state}, 64'd1);
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 0, 20, 1'b1, 1'b0, 1'b0, 0, 0);
      if (i == 15) chk("settle_15", {62'd0, o_state}, 64'd1);
    end
    chk("settle_done", {62'd0, o_state}, 64'd2);
    chk("settle_taps", {1'b0, o_coefs}, {1'b0, INIT_COEFS});

    // Single update: e=12, x0=128 -> C0 = 12
    cycle(1'b1, 128, 20, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("single_upd", {1'b0, o_coefs}, {1'b0, INIT_COEFS + 63'd12});

    // Saturation on C0 (e=32): ceiling, back inward, floor, floor held, back inward
    cycle(1'b1, 1023, -128, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("sat_hi", {55'd0, o_coefs[8:0]}, 64'h0ff);
    cycle(1'b1, -1024, -128, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("sat_in", {55'd0, o_coefs[8:0]}, 64'h1ff);
    cycle(1'b1, -1024, -128, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("sat_lo", {55'd0, o_coefs[8:0]}, 64'h100);
    cycle(1'b1, -1024, -128, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("sat_lo_hold", {55'd0, o_coefs[8:0]}, 64'h100);
    cycle(1'b1, 1023, -128, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("sat_release", {55'd0, o_coefs[8:0]}, 64'h000);

    // Hold: taps frozen across strobes
    cycle(1'b1, 300, 50, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("enter_hold", {62'd0, o_state}, 64'd3);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 37 * i - 200, 90 - 20 * i, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    chk("hold_c0", {55'd0, o_coefs[8:0]}, 64'h000);
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("hold_to_adapt", {62'd0, o_state}, 64'd2);

    // Reinit with a strobe in ADAPT: initial taps, IDLE, no update
    cycle(1'b1, 500, -128, 1'b1, 1'b1, 1'b0, 0, 0);
    chk("reinit_taps", {1'b0, o_coefs}, {1'b0, INIT_COEFS});
    chk("reinit_state", {62'd0, o_state}, 64'd0);
    cycle(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Back to ADAPT with a populated delay line, then async reset
    cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 10 * i - 70, 7 * i - 100, 1'b1, 1'b0, 1'b0, 0, 0);
    end
    cycle(1'b1, 200, 30, 1'b1, 1'b0, 1'b0, 0, 0);
    chk("pre_rst_state", {62'd0, o_state}, 64'd2);
    @(negedge clk);
    i_en = 1'b0; i_adapt_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_coefs", {1'b0, o_coefs}, {1'b0, INIT_COEFS});
    chk("async_rst_state", {62'd0, o_state}, 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 64, -10, 1'b0, 1'b0, 1'b0, 0, 0);
    cycle(1'b1, -5, 120, 1'b0, 1'b0, 1'b0, 0, 0);

    @(negedge clk);
    #1;
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
